// File: rtl/letc_pkg.sv
// Shared LETC core-side memory definitions: bus widths, request struct, requester ID type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package letc_pkg;

    localparam int LETC_MEM_ADDR_W = 32;
    localparam int LETC_MEM_DATA_W = 32;
    localparam int LETC_NUM_REQ    = 2;

    // One memory request as seen on the SoC side.
    typedef struct packed {
        logic [LETC_MEM_ADDR_W-1:0]   addr;
        logic                         wen;
        logic [LETC_MEM_DATA_W-1:0]   wdata;
        logic [LETC_MEM_DATA_W/8-1:0] wstrb;
    } mem_req_s;

    typedef logic [$clog2(LETC_NUM_REQ)-1:0] req_id_t;

    // Index width that stays legal (>=1 bit) when only one entry exists.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/letc_fifo.sv
// Generic synchronous FIFO, WIDTH bits x DEPTH entries.
// Latency: push visible on pop_dat the cycle after the push; pop_dat shows the head combinationally.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps the count.
// Ports: clk, rst (async, active-high), push/push_dat, pop/pop_dat, full, empty.
module letc_fifo
    import letc_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/letc_mem_arbiter.sv
// Round-robin merge of NUM_REQ core request ports onto one SoC memory port; in-order responses routed back by ID.
// Latency: accept in cycle N -> mem_req_valid in N+1; 1 request/cycle sustained; response routed combinationally.
// Backpressure: req_ready only when the output register is empty/draining and fewer than MAX_OUTSTANDING are in flight.
// Ports: clk, rst; req_valid/ready/addr/wen/wdata/wstrb per requester; rsp_valid per requester, shared rsp_rdata;
//        mem_req_valid/ready/addr/wen/wdata/wstrb; mem_rsp_valid/rdata; err_unexp_rsp (sticky).
module letc_mem_arbiter
    import letc_pkg::*;
#(
    parameter int NUM_REQ         = LETC_NUM_REQ,
    parameter int ADDR_W          = LETC_MEM_ADDR_W,
    parameter int DATA_W          = LETC_MEM_DATA_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]                 req_wen,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_W-1:0]                  rsp_rdata,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_W-1:0]                  mem_req_addr,
    output logic                               mem_req_wen,
    output logic [DATA_W-1:0]                  mem_req_wdata,
    output logic [DATA_W/8-1:0]                mem_req_wstrb,
    input  logic                               mem_rsp_valid,
    input  logic [DATA_W-1:0]                  mem_rsp_rdata,
    output logic                               err_unexp_rsp
);

    localparam int ID_W   = clog2_min1(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic            any_vld;
    logic            drain;
    logic            load;
    logic            accept;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head_id;
    logic            rsp_pop;
    req_t            granted;
    req_t            out_q;

    // Scan from rr_ptr upward with wrap; walking k downward lets the nearest requester overwrite farther ones.
    always_comb begin
        int idx;
        winner  = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                winner  = ID_W'(idx);
                any_vld = 1'b1;
            end
        end
    end

    assign drain  = mem_req_valid & mem_req_ready;
    // fifo_full is registered state only, so a same-cycle response cannot reopen acceptance.
    // rst gating keeps every output low while reset is asserted, even with requests pending.
    assign load   = (~mem_req_valid | drain) & ~fifo_full & ~rst;
    assign accept = load & any_vld;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        granted.addr  = req_addr[winner];
        granted.wen   = req_wen[winner];
        granted.wdata = req_wdata[winner];
        granted.wstrb = req_wstrb[winner];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q         <= '0;
            mem_req_valid <= 1'b0;
            rr_ptr        <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (accept) begin
                out_q         <= granted;
                mem_req_valid <= 1'b1;
                rr_ptr        <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end else if (drain) begin
                mem_req_valid <= 1'b0;
            end
            if (mem_rsp_valid & fifo_empty) begin
                err_unexp_rsp <= 1'b1;
            end
        end
    end

    assign mem_req_addr  = out_q.addr;
    assign mem_req_wen   = out_q.wen;
    assign mem_req_wdata = out_q.wdata;
    assign mem_req_wstrb = out_q.wstrb;

    // Responses arrive in issue order, so the FIFO head names the requester that owns this one.
    assign rsp_pop = mem_rsp_valid & ~fifo_empty & ~rst;

    always_comb begin
        rsp_valid = '0;
        if (rsp_pop) begin
            rsp_valid[head_id] = 1'b1;
        end
    end

    assign rsp_rdata = rsp_pop ? mem_rsp_rdata : '0;

    letc_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat (winner),
        .pop      (rsp_pop),
        .pop_dat  (head_id),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_letc_mem_arbiter.sv
module tb_letc_mem_arbiter;

    localparam int NR   = 2;
    localparam int MAXO = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0][31:0]  req_addr;
    logic [NR-1:0]        req_wen;
    logic [NR-1:0][31:0]  req_wdata;
    logic [NR-1:0][3:0]   req_wstrb;
    logic [NR-1:0]        rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [31:0]          mem_req_addr;
    logic                 mem_req_wen;
    logic [31:0]          mem_req_wdata;
    logic [3:0]           mem_req_wstrb;
    logic                 mem_rsp_valid;
    logic [31:0]          mem_rsp_rdata;
    logic                 err_unexp_rsp;

    letc_mem_arbiter #(
        .NUM_REQ         (NR),
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wen       (req_wen),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: arbitration pointer, list of in-flight requester IDs, pending downstream request.
    int          m_rr;
    int          m_q[$];
    bit          m_vld;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    bit          m_err;

    logic [NR-1:0] got_rdy;
    int            grants[$];
    logic [31:0]   hs_addr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_q.delete();
        m_vld   = 0;
        m_addr  = '0;
        m_wen   = 1'b0;
        m_wdata = '0;
        m_strb  = '0;
        m_err   = 0;
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        req_addr      = '0;
        req_wen       = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NR; i++) begin
            req_addr[i]  = $urandom;
            req_wen[i]   = 1'($urandom_range(1));
            req_wdata[i] = $urandom;
            req_wstrb[i] = 4'($urandom_range(15));
        end
    endtask

    // One clock: inputs are already applied; compare at the falling edge, then advance the model.
    task automatic cyc(input string tag);
        bit            found;
        int            w;
        bit            drain;
        bit            can_load;
        bit            pop;
        logic [NR-1:0] e_rdy;
        logic [NR-1:0] e_rsp;
        @(negedge clk);
        drain    = m_vld && mem_req_ready;
        can_load = (!m_vld || drain) && (m_q.size() < MAXO);
        found = 0;
        w     = 0;
        for (int k = 0; k < NR; k++) begin
            if (!found && req_valid[(m_rr + k) % NR]) begin
                found = 1;
                w     = (m_rr + k) % NR;
            end
        end
        e_rdy = '0;
        if (can_load && found) e_rdy[w] = 1'b1;
        pop   = mem_rsp_valid && (m_q.size() > 0);
        e_rsp = '0;
        if (pop) e_rsp[m_q[0]] = 1'b1;

        check({tag, ".req_ready"}, 64'(req_ready), 64'(e_rdy));
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(e_rsp));
        if (pop) check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(mem_rsp_rdata));
        check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'(m_vld));
        if (m_vld) begin
            check({tag, ".mem_req_addr"}, 64'(mem_req_addr), 64'(m_addr));
            check({tag, ".mem_req_wen"}, 64'(mem_req_wen), 64'(m_wen));
            check({tag, ".mem_req_wdata"}, 64'(mem_req_wdata), 64'(m_wdata));
            check({tag, ".mem_req_wstrb"}, 64'(mem_req_wstrb), 64'(m_strb));
        end
        check({tag, ".err_unexp_rsp"}, 64'(err_unexp_rsp), 64'(m_err));

        got_rdy = req_ready;
        if (mem_req_valid && mem_req_ready) hs_addr.push_back(mem_req_addr);
        if (mem_rsp_valid && m_q.size() == 0) m_err = 1;
        if (pop) void'(m_q.pop_front());
        if (e_rdy != '0) begin
            grants.push_back(w);
            m_q.push_back(w);
            m_rr    = (w + 1) % NR;
            m_vld   = 1;
            m_addr  = req_addr[w];
            m_wen   = req_wen[w];
            m_wdata = req_wdata[w];
            m_strb  = req_wstrb[w];
        end else if (drain) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.req_ready", 64'(req_ready), 64'(0));
        check("reset.mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("reset.mem_req_addr", 64'(mem_req_addr), 64'(0));
        check("reset.rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset.err", 64'(err_unexp_rsp), 64'(0));
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;

        // Reset state.
        do_reset();

        // Both ports every cycle, responses two cycles after each downstream handshake.
        grants.delete();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            req_valid     = (i < 8) ? 2'b11 : 2'b00;
            rand_fields();
            mem_rsp_valid = (i >= 3 && i < 11);
            mem_rsp_rdata = $urandom;
            cyc("t1");
        end
        check("t1.grant0", 64'(grants[0]), 64'(0));
        check("t1.grant1", 64'(grants[1]), 64'(1));
        check("t1.grant2", 64'(grants[2]), 64'(0));
        check("t1.grant3", 64'(grants[3]), 64'(1));

        // Port 0 only, downstream stalled for three cycles.
        do_reset();
        hs_addr.delete();
        req_valid   = 2'b01;
        req_addr[0] = 32'h100;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            mem_req_ready = (i >= 4);
            cyc("t2");
            if (i >= 1 && i <= 3) check("t2.stall_addr", 64'(mem_req_addr), 64'h100);
            if (got_rdy[0]) begin
                n++;
                req_addr[0] = req_addr[0] + 32'd4;
                if (n == 3) req_valid = 2'b00;
            end
        end
        check("t2.hs_count", 64'(hs_addr.size()), 64'(3));
        if (hs_addr.size() == 3) begin
            check("t2.hs0", 64'(hs_addr[0]), 64'h100);
            check("t2.hs1", 64'(hs_addr[1]), 64'h104);
            check("t2.hs2", 64'(hs_addr[2]), 64'h108);
        end

        // Fill the in-flight FIFO, then free one slot.
        do_reset();
        req_valid     = 2'b01;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            cyc("t3.fill");
        end
        check("t3.fifth_blocked", 64'(got_rdy), 64'(0));
        mem_rsp_valid = 1'b1;
        cyc("t3.pop");
        check("t3.same_cycle_blocked", 64'(got_rdy), 64'(0));
        mem_rsp_valid = 1'b0;
        cyc("t3.reopen");
        check("t3.next_cycle_ready", 64'(got_rdy), 64'(1));

        // Response with nothing outstanding.
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1234_5678;
        cyc("t4.unexp");
        mem_rsp_valid = 1'b0;
        repeat (3) cyc("t4.sticky");
        check("t4.err_sticky", 64'(err_unexp_rsp), 64'(1));
        do_reset();

        // Asynchronous reset with three requests in flight.
        req_valid     = 2'b01;
        mem_req_ready = 1'b1;
        repeat (3) cyc("t5.issue");
        mem_rsp_valid = 1'b1;
        rst = 1'b1;
        #2;
        check("t5.async_mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("t5.async_req_ready", 64'(req_ready), 64'(0));
        check("t5.async_rsp_valid", 64'(rsp_valid), 64'(0));
        rst = 1'b0;
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        req_valid     = 2'b10;
        mem_req_ready = 1'b1;
        cyc("t5.after");
        check("t5.port1_granted", 64'(got_rdy), 64'(2));
        req_valid     = 2'b00;
        mem_rsp_valid = 1'b1;
        cyc("t5.rsp");
        mem_rsp_valid = 1'b0;
        cyc("t5.idle");

        // Response to port 1 coinciding with acceptance from port 0.
        do_reset();
        mem_req_ready = 1'b1;
        req_valid     = 2'b10;
        cyc("t6.p1");
        req_valid     = 2'b01;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t6.rsp_valid", 64'(rsp_valid), 64'(2));
        check("t6.rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        check("t6.req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        // Keep the model in step with the cycle just checked by hand.
        void'(m_q.pop_front());
        m_q.push_back(0);
        m_rr = 1; m_vld = 1; m_addr = req_addr[0]; m_wen = req_wen[0];
        m_wdata = req_wdata[0]; m_strb = req_wstrb[0];
        req_valid     = 2'b00;
        mem_rsp_rdata = 32'h0BAD_F00D;
        cyc("t6.p0_rsp");
        check("t6.second_rsp_port0", 64'(got_rdy), 64'(0));
        mem_rsp_valid = 1'b0;
        cyc("t6.empty");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid     = 2'($urandom_range(3));
            rand_fields();
            mem_req_ready = ($urandom_range(3) != 0);
            mem_rsp_valid = ($urandom_range(2) == 0);
            mem_rsp_rdata = $urandom;
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
